// File: rtl/memory_access_if.sv
// memory_access_if: data-memory bus between the memory stage and its memory.
interface memory_access_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [63:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        mem_err_i;
  modport master (output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
                  input  mem_rdata_i, mem_ack_i, mem_err_i);
  modport slave  (input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
                  output mem_rdata_i, mem_ack_i, mem_err_i);
endinterface

// File: rtl/memory_access.sv
// memory_access: Y86 memory stage issuing one bus access per instruction with timeout and range check.
module memory_access #(
  parameter int MEM_BYTES = 4096,
  parameter int TIMEOUT   = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        memory_bubble_i,
  input  logic        memory_stall_i,
  input  logic [3:0]  icode_i,
  input  logic [2:0]  stat_i,
  input  logic [63:0] valE_i,
  input  logic [63:0] valA_i,
  input  logic [63:0] valP_i,
  input  logic [3:0]  dstE_i,
  input  logic [3:0]  dstM_i,
  memory_access_if.master bus,
  output logic [63:0] valM_o,
  output logic [63:0] valE_o,
  output logic [3:0]  dstE_o,
  output logic [3:0]  dstM_o,
  output logic [2:0]  stat_o,
  output logic        stall_o
);
  localparam logic [3:0] IRMMOVQ = 4'h4, IMRMOVQ = 4'h5, ICALL = 4'h8,
                         IRET = 4'h9, IPUSHQ = 4'hA, IPOPQ = 4'hB, RNONE = 4'hF;
  localparam logic [2:0] SAOK = 3'd1, SADR = 3'd3;
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic          err_q, is_rd, is_wr, need, ok, to_hit;
  logic [63:0]   addr;
  assign is_rd  = icode_i inside {IMRMOVQ, IPOPQ, IRET};
  assign is_wr  = icode_i inside {IRMMOVQ, IPUSHQ, ICALL};
  assign need   = (is_rd | is_wr) & ~memory_bubble_i & (stat_i == SAOK);
  assign addr   = (icode_i == IPOPQ || icode_i == IRET) ? valA_i : valE_i;
  // a single compare against MEM_BYTES-8 sidesteps the addr+8 wraparound
  assign ok     = addr <= 64'(MEM_BYTES - 8);
  assign to_hit = cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state <= IDLE;
    else          state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (need && ok) ? BUSY : IDLE;
      BUSY:    state_n = (bus.mem_ack_i || to_hit) ? DONE : BUSY;
      default: state_n = memory_stall_i ? DONE : IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      bus.mem_we_o    <= 1'b0;
      bus.mem_addr_o  <= '0;
      bus.mem_wdata_o <= '0;
      valM_o          <= '0;
      err_q           <= 1'b0;
      cnt             <= '0;
    end else if (state == IDLE && need && ok) begin
      bus.mem_we_o    <= is_wr;
      bus.mem_addr_o  <= addr;
      bus.mem_wdata_o <= (icode_i == ICALL) ? valP_i : valA_i;
      err_q           <= 1'b0;
      cnt             <= '0;
    end else if (state == BUSY) begin
      if (bus.mem_ack_i) begin
        if (!bus.mem_we_o) valM_o <= bus.mem_rdata_i;
        err_q <= bus.mem_err_i;
      end else begin
        cnt <= cnt + 1'b1;
        if (to_hit) err_q <= 1'b1;
      end
    end
  assign bus.mem_req_o = state == BUSY;
  assign stall_o = (state == IDLE && need && ok) || state == BUSY;
  assign valE_o  = valE_i;
  assign dstE_o  = memory_bubble_i ? RNONE : dstE_i;
  assign dstM_o  = memory_bubble_i ? RNONE : dstM_i;
  assign stat_o  = memory_bubble_i ? SAOK :
                   state == DONE ? (err_q ? SADR : stat_i) :
                   (state == IDLE && need && !ok) ? SADR : stat_i;
endmodule
